pipe_addsub: RTL and testbench
==============================

// Module: pipe_addsub
// PURPOSE
//   Parametrised, pipelined add/subtract unit: the successor to the plain combinational 32-bit adder.
//   Splits a WIDTH-bit add into STAGES carry-chained chunks, one chunk per cycle.
//   Adds subtract mode, carry-in and status flags, plus a valid/ready handshake on each side.
//   Sits between the operand-select muxes and the writeback/ALU result mux in the datapath.
// PARAMETERS
//   WIDTH   32  operand/result width in bits; WIDTH % STAGES must be 0
//   STAGES  4   pipeline depth = number of chunks; 1 <= STAGES <= WIDTH
// PORTS
//   clk        in   1      single clock, all state on rising edge
//   rst        in   1      synchronous reset, active-high
//   in_valid   in   1      operand beat present
//   in_ready   out  1      unit accepts the beat this cycle
//   op_sub     in   1      0 = A+B+cin; 1 = A-B (A + ~B + 1; cin ignored)
//   cin        in   1      carry-in for add mode
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   out_valid  out  1      result beat present
//   out_ready  in   1      consumer takes the beat this cycle
//   sum        out  WIDTH  result, modulo 2^WIDTH
//   cout       out  1      carry out of MSB (sub: 1 = no borrow)
//   ovf        out  1      signed two's-complement overflow
//   zero       out  1      sum == 0
//   neg        out  1      sum[WIDTH-1]
//   busy       out  1      OR of all stage valid bits
// BEHAVIOUR
// - Reset (rst=1 at a clock edge): every stage valid bit clears.
//   out_valid=0, busy=0; sum/cout/ovf/zero/neg = 0. in_ready follows the stall rule, so it is 1 after reset.
// - Reset mid-operation: all in-flight beats are discarded, never emitted. A beat offered in the reset cycle is not accepted.
// - Advance: adv = !out_valid || out_ready; in_ready = adv (combinational from out_ready, intended).
// - Transfer: a beat is accepted when in_valid && in_ready. On adv all stages shift by one, including bubbles.
//   When adv=0 every stage register holds, so outputs remain stable while out_valid && !out_ready.
// - Latency: exactly STAGES cycles, accept edge to out_valid, when not stalled. Throughput is 1 beat/cycle.
// - Stage k (0..STAGES-1), with CHUNK = WIDTH/STAGES:
//   - Adds bits [k*CHUNK +: CHUNK] of a and b' = op_sub ? ~b : b, plus the carry registered by stage k-1.
//   - Stage 0 carry-in = op_sub ? 1 : cin.
//   - Not-yet-added upper chunks of a/b' are delay-registered alongside; completed lower sum chunks accumulate.
// - Flags are registered with the final stage, so they are valid exactly when out_valid=1:
//   - cout = carry out of bit WIDTH-1.
//   - ovf = carry into MSB XOR carry out of MSB; stage STAGES-1 computes it inside its chunk.
//   - zero = ~|sum; neg = sum[WIDTH-1].
// - Arithmetic wraps mod 2^WIDTH; no saturation. op_sub and cin are sampled only at accept.
// - STAGES=1 is a single registered stage (latency 1). STAGES=WIDTH gives 1-bit chunks.
// - Illegal parameters (WIDTH % STAGES != 0): elaboration-time $error in a generate check.
// STRUCTURE
// - Shared package alu_pkg: OP_ADD=1'b0, OP_SUB=1'b1, and the flag bit indices (FLG_C, FLG_V, FLG_Z, FLG_N) used by the flags register.
// - One sub-module, addsub_slice #(CHUNK): CHUNK-bit add of a/b' chunk with cin.
//   It returns the chunk sum, cout, and carry-into-MSB, the last used only by the top slice.
// - pipe_addsub generate-loops STAGES slices with valid bits, delay registers and the global adv enable.
// TESTING (WIDTH=32, STAGES=4 unless stated)
// 1. Add a=FFFFFFFF, b=00000001, cin=0 -> 4 cycles later sum=00000000, cout=1, zero=1, ovf=0, neg=0.
// 2. Add a=7FFFFFFF, b=00000001 -> sum=80000000, ovf=1, neg=1, cout=0; add with cin=1, a=b=0 -> sum=1.
// 3. Sub a=5, b=7 -> sum=FFFFFFFE, cout=0 (borrow), neg=1; sub a=7, b=7 -> sum=0, cout=1, zero=1.
// 4. Back-to-back beats 1+1, 2+2, 3+3, 4+4, 5+5; drop out_ready for 3 cycles when first result appears
//    -> in_ready=0 while stalled, sum holds 2, then results 2,4,6,8,10 in order, none lost or duplicated.
// 5. Three beats in flight, assert rst for 1 cycle -> next cycle out_valid=0, busy=0, in_ready=1; no stale result ever appears.
// 6. STAGES in {1, 4, 32}: 10k random ops with random in_valid/out_ready vs reference model -> all sums and flags match, order kept.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU encodings: add/sub opcode values and bit positions in the flags register.
package alu_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int unsigned FLG_C     = 0;
  localparam int unsigned FLG_V     = 1;
  localparam int unsigned FLG_Z     = 2;
  localparam int unsigned FLG_N     = 3;
  localparam int unsigned NUM_FLAGS = 4;

endpackage

// File: rtl/addsub_slice.sv
// One chunk of the carry chain: CHUNK-bit add with carry-in, reporting carry out and the
// carry into the chunk MSB (needed for signed overflow in the top chunk).
module addsub_slice #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  always_comb begin
    {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    // sum bit = a ^ b ^ carry-in, so the carry into the MSB falls out directly
    cmsb = a[CHUNK-1] ^ b[CHUNK-1] ^ sum[CHUNK-1];
  end

endmodule

// File: rtl/pipe_addsub.sv
// Pipelined add/subtract: WIDTH-bit operation split into STAGES carry-chained chunks,
// one chunk per cycle, with valid/ready handshakes and registered status flags.
module pipe_addsub
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg,
  output logic             busy
);

  localparam int unsigned CHUNK = WIDTH / STAGES;
  localparam int unsigned NMID  = (STAGES > 1) ? STAGES - 1 : 1;

  if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_bad_params
    $error("pipe_addsub: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
  end

  logic                 adv;
  logic [STAGES-1:0]    vld_q, vld_d;
  logic [WIDTH-1:0]     b_eff;
  logic                 cin_eff;

  // Inter-stage registers: operands still to be added, carry, and accumulated low sum chunks
  logic [WIDTH-1:0]     opa_q  [NMID];
  logic [WIDTH-1:0]     opb_q  [NMID];
  logic [WIDTH-1:0]     psum_q [NMID];
  logic                 carry_q[NMID];

  // Per-stage inputs (stage 0 from ports, stage k from registers of stage k-1)
  logic [WIDTH-1:0]     src_a  [STAGES];
  logic [WIDTH-1:0]     src_b  [STAGES];
  logic [WIDTH-1:0]     src_p  [STAGES];
  logic                 src_c  [STAGES];

  logic [WIDTH-1:0]     sum_q;
  logic [NUM_FLAGS-1:0] flags_q;

  assign adv       = !vld_q[STAGES-1] || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_q[STAGES-1];
  assign busy      = |vld_q;
  assign sum       = sum_q;
  assign cout      = flags_q[FLG_C];
  assign ovf       = flags_q[FLG_V];
  assign zero      = flags_q[FLG_Z];
  assign neg       = flags_q[FLG_N];

  assign b_eff   = (op_sub == OP_SUB) ? ~b : b;
  assign cin_eff = (op_sub == OP_SUB) ? 1'b1 : cin;

  always_comb begin
    vld_d    = vld_q << 1;
    vld_d[0] = in_valid;
  end

  // Every stage, bubbles included, moves together on adv
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else if (adv) begin
      vld_q <= vld_d;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CHUNK-1:0] chunk_sum;
    logic             chunk_cout;
    logic             chunk_cmsb;
    logic [WIDTH-1:0] nxt_sum;

    if (k == 0) begin : g_src
      assign src_a[k] = a;
      assign src_b[k] = b_eff;
      assign src_c[k] = cin_eff;
      assign src_p[k] = '0;
    end else begin : g_src
      assign src_a[k] = opa_q[k-1];
      assign src_b[k] = opb_q[k-1];
      assign src_c[k] = carry_q[k-1];
      assign src_p[k] = psum_q[k-1];
    end

    addsub_slice #(
      .CHUNK (CHUNK)
    ) u_slice (
      .a    (src_a[k][k*CHUNK +: CHUNK]),
      .b    (src_b[k][k*CHUNK +: CHUNK]),
      .cin  (src_c[k]),
      .sum  (chunk_sum),
      .cout (chunk_cout),
      .cmsb (chunk_cmsb)
    );

    always_comb begin
      nxt_sum                     = src_p[k];
      nxt_sum[k*CHUNK +: CHUNK]   = chunk_sum;
    end

    if (k < STAGES - 1) begin : g_mid
      always_ff @(posedge clk) begin
        if (rst) begin
          opa_q[k]   <= '0;
          opb_q[k]   <= '0;
          psum_q[k]  <= '0;
          carry_q[k] <= 1'b0;
        end else if (adv) begin
          opa_q[k]   <= src_a[k];
          opb_q[k]   <= src_b[k];
          psum_q[k]  <= nxt_sum;
          carry_q[k] <= chunk_cout;
        end
      end
    end else begin : g_last
      always_ff @(posedge clk) begin
        if (rst) begin
          sum_q   <= '0;
          flags_q <= '0;
        end else if (adv) begin
          sum_q          <= nxt_sum;
          flags_q[FLG_C] <= chunk_cout;
          flags_q[FLG_V] <= chunk_cout ^ chunk_cmsb;
          flags_q[FLG_Z] <= ~|nxt_sum;
          flags_q[FLG_N] <= nxt_sum[WIDTH-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_addsub.sv
// Bench for pipe_addsub: directed checks on a 4-stage unit plus randomized traffic on
// 1-, 4- and 32-stage units compared against an arithmetic reference model.
module tb_pipe_addsub;

  typedef struct packed {
    logic [31:0] s;
    logic        c;
    logic        v;
    logic        z;
    logic        n;
  } res_t;

  localparam int NRAND = 10000;

  logic        clk = 1'b0;
  logic        rst;
  logic        iv   [3];
  logic        irdy [3];
  logic        isub [3];
  logic        icin [3];
  logic [31:0] ia   [3];
  logic [31:0] ib   [3];
  logic        ov   [3];
  logic        ordy [3];
  logic [31:0] osum [3];
  logic        oc   [3];
  logic        oovf [3];
  logic        oz   [3];
  logic        on   [3];
  logic        obusy[3];

  int   total = 0;
  int   bad   = 0;
  res_t expq [3][$];

  always #5 clk = ~clk;

  pipe_addsub #(.WIDTH(32), .STAGES(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(irdy[0]), .op_sub(isub[0]),
    .cin(icin[0]), .a(ia[0]), .b(ib[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
    .sum(osum[0]), .cout(oc[0]), .ovf(oovf[0]), .zero(oz[0]), .neg(on[0]), .busy(obusy[0])
  );

  pipe_addsub #(.WIDTH(32), .STAGES(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(irdy[1]), .op_sub(isub[1]),
    .cin(icin[1]), .a(ia[1]), .b(ib[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
    .sum(osum[1]), .cout(oc[1]), .ovf(oovf[1]), .zero(oz[1]), .neg(on[1]), .busy(obusy[1])
  );

  pipe_addsub #(.WIDTH(32), .STAGES(32)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(irdy[2]), .op_sub(isub[2]),
    .cin(icin[2]), .a(ia[2]), .b(ib[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
    .sum(osum[2]), .cout(oc[2]), .ovf(oovf[2]), .zero(oz[2]), .neg(on[2]), .busy(obusy[2])
  );

  // Reference: plain unsigned/signed integer arithmetic on the operands
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic sub, input logic cin);
    res_t        r;
    longint      sa = longint'($signed(a));
    longint      sb = longint'($signed(b));
    longint      sr;
    logic [32:0] u;
    if (sub) begin
      r.s = a - b;
      r.c = (a >= b);
      sr  = sa - sb;
    end else begin
      u   = {1'b0, a} + {1'b0, b} + {32'd0, cin};
      r.s = u[31:0];
      r.c = u[32];
      sr  = sa + sb + longint'(cin);
    end
    r.v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    r.z = (r.s == 32'd0);
    r.n = r.s[31];
    return r;
  endfunction

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    for (int d = 0; d < 3; d++) begin
      iv[d]   = 1'b0;
      isub[d] = 1'b0;
      icin[d] = 1'b0;
      ia[d]   = '0;
      ib[d]   = '0;
      ordy[d] = 1'b1;
    end
  endtask

  // Offers one beat to the 4-stage unit and waits (bounded) for its result
  task automatic run_single(input logic [31:0] a, input logic [31:0] b, input logic sub,
                            input logic cin, output int lat, output res_t got);
    int n;
    iv[1]   = 1'b1;
    ia[1]   = a;
    ib[1]   = b;
    isub[1] = sub;
    icin[1] = cin;
    ordy[1] = 1'b1;
    tick();
    iv[1] = 1'b0;
    n = 1;
    while (!ov[1] && n < 12) begin
      tick();
      n++;
    end
    lat = ov[1] ? n : 99;
    got = {osum[1], oc[1], oovf[1], oz[1], on[1]};
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_all();
    tick();
    tick();
    for (int d = 0; d < 3; d++) begin
      total++;
      if (ov[d] !== 1'b0 || obusy[d] !== 1'b0) begin
        bad++;
        $display("FAIL reset_valid[%0d]: got out_valid=%b busy=%b want 0 0", d, ov[d], obusy[d]);
      end
      total++;
      if ({osum[d], oc[d], oovf[d], oz[d], on[d]} !== 36'd0) begin
        bad++;
        $display("FAIL reset_data[%0d]: got sum=%h c=%b v=%b z=%b n=%b want all 0",
                 d, osum[d], oc[d], oovf[d], oz[d], on[d]);
      end
    end
    rst = 1'b0;
    #1;
    total++;
    if (irdy[1] !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready: got %b want 1", irdy[1]);
    end
  endtask

  task automatic test_add();
    int   lat;
    res_t got;
    res_t want;
    run_single(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, lat, got);
    want = {32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
    total++;
    if (lat !== 4) begin
      bad++;
      $display("FAIL add_latency: got %0d want 4", lat);
    end
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL add_wrap: got %h want %h", got, want);
    end
    run_single(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, lat, got);
    want = {32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1};
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL add_ovf: got %h want %h", got, want);
    end
    run_single(32'h0, 32'h0, 1'b0, 1'b1, lat, got);
    want = {32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0};
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL add_cin: got %h want %h", got, want);
    end
  endtask

  task automatic test_sub();
    int   lat;
    res_t got;
    res_t want;
    run_single(32'd5, 32'd7, 1'b1, 1'b1, lat, got);
    want = {32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1};
    total++;
    if (got !== want || lat !== 4) begin
      bad++;
      $display("FAIL sub_borrow: got %h lat %0d want %h lat 4", got, lat, want);
    end
    run_single(32'd7, 32'd7, 1'b1, 1'b0, lat, got);
    want = {32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL sub_equal: got %h want %h", got, want);
    end
  endtask

  task automatic test_back_to_back();
    int          nxt   = 1;
    int          stall = 0;
    int          cyc   = 0;
    int          extra = 0;
    bit          seen  = 0;
    logic [31:0] got[$];
    idle_all();
    while (got.size() < 5 && cyc < 60) begin
      if (ov[1] && !seen) seen = 1;
      if (seen && stall < 3) begin
        ordy[1] = 1'b0;
        stall++;
      end else begin
        ordy[1] = 1'b1;
      end
      iv[1] = (nxt <= 5);
      ia[1] = nxt;
      ib[1] = nxt;
      #1;
      if (!ordy[1]) begin
        total++;
        if (irdy[1] !== 1'b0 || ov[1] !== 1'b1 || osum[1] !== 32'd2) begin
          bad++;
          $display("FAIL b2b_stall: got in_ready=%b out_valid=%b sum=%0d want 0 1 2",
                   irdy[1], ov[1], osum[1]);
        end
      end
      if (ov[1] && ordy[1]) got.push_back(osum[1]);
      if (iv[1] && irdy[1]) nxt++;
      tick();
      cyc++;
    end
    iv[1]   = 1'b0;
    ordy[1] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (ov[1]) extra++;
      tick();
    end
    total++;
    if (got.size() != 5 || extra != 0) begin
      bad++;
      $display("FAIL b2b_count: got %0d results (+%0d extra) want 5 (+0)", got.size(), extra);
    end
    for (int i = 0; i < got.size(); i++) begin
      total++;
      if (got[i] !== 32'(2 * (i + 1))) begin
        bad++;
        $display("FAIL b2b_order[%0d]: got %0d want %0d", i, got[i], 2 * (i + 1));
      end
    end
  endtask

  task automatic test_reset_mid();
    int stale = 0;
    idle_all();
    for (int i = 0; i < 3; i++) begin
      iv[1] = 1'b1;
      ia[1] = 32'(10 * (i + 1));
      ib[1] = 32'd1;
      tick();
    end
    rst   = 1'b1;
    ia[1] = 32'd99;
    tick();
    rst   = 1'b0;
    iv[1] = 1'b0;
    #1;
    total++;
    if (ov[1] !== 1'b0 || obusy[1] !== 1'b0 || irdy[1] !== 1'b1) begin
      bad++;
      $display("FAIL midreset_state: got out_valid=%b busy=%b in_ready=%b want 0 0 1",
               ov[1], obusy[1], irdy[1]);
    end
    for (int i = 0; i < 10; i++) begin
      if (ov[1]) stale++;
      tick();
    end
    total++;
    if (stale != 0) begin
      bad++;
      $display("FAIL midreset_stale: got %0d stale results want 0", stale);
    end
  endtask

  task automatic test_random();
    int   issued[3] = '{0, 0, 0};
    int   done[3]   = '{0, 0, 0};
    bit   hold[3]   = '{0, 0, 0};
    res_t held[3];
    res_t act;
    res_t e;
    int   cyc = 0;
    idle_all();
    while (cyc < 40000 && !(done[0] == NRAND && done[1] == NRAND && done[2] == NRAND)) begin
      for (int d = 0; d < 3; d++) begin
        ordy[d] = ($urandom_range(0, 3) != 0);
        iv[d]   = (issued[d] < NRAND) && ($urandom_range(0, 3) != 0);
        ia[d]   = rand_op();
        ib[d]   = rand_op();
        isub[d] = 1'($urandom_range(0, 1));
        icin[d] = 1'($urandom_range(0, 1));
      end
      #1;
      for (int d = 0; d < 3; d++) begin
        act = {osum[d], oc[d], oovf[d], oz[d], on[d]};
        if (hold[d]) begin
          total++;
          if (ov[d] !== 1'b1 || act !== held[d]) begin
            bad++;
            $display("FAIL rand_hold[%0d]: got valid=%b %h want 1 %h", d, ov[d], act, held[d]);
          end
        end
        total++;
        if (irdy[d] !== (!ov[d] || ordy[d])) begin
          bad++;
          $display("FAIL rand_in_ready[%0d]: got %b want %b", d, irdy[d], !ov[d] || ordy[d]);
        end
        if (ov[d] && ordy[d]) begin
          total++;
          if (expq[d].size() == 0) begin
            bad++;
            $display("FAIL rand_unexpected[%0d]: got result %h want none", d, act);
          end else begin
            e = expq[d].pop_front();
            done[d]++;
            if (act !== e) begin
              bad++;
              $display("FAIL rand_result[%0d]: got %h want %h", d, act, e);
            end
          end
        end
        hold[d] = ov[d] && !ordy[d];
        held[d] = act;
        if (iv[d] && irdy[d]) begin
          expq[d].push_back(model(ia[d], ib[d], isub[d], icin[d]));
          issued[d]++;
        end
      end
      tick();
      cyc++;
    end
    for (int d = 0; d < 3; d++) begin
      total++;
      if (done[d] != NRAND) begin
        bad++;
        $display("FAIL rand_done[%0d]: got %0d results want %0d", d, done[d], NRAND);
      end
    end
    idle_all();
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
